ab_seq_gen: RTL and testbench
=============================

// Module: ab_seq_gen
// PURPOSE
//  Stimulus source for the A-then-B sequence detector (detector output Q).
//  - Drives A/B to emit N programmed "A pulse, then B held H cycles" sequences.
//  - Checks returned Q cycle-by-cycle, counts correctly detected pulses.
//  - Reports a sticky error on any Q mismatch.
//  Sits in front of the detector on the same clock/reset as a self-checking driver.
// PARAMETERS
//  CNT_W   8  width of pulse count n_pulses and pulses_ok
//  HOLD_W  4  width of B hold length b_hold
//  GAP     2  idle cycles (A=B=0) after each B hold; must be >=2, elaborate-time error otherwise
// PORTS
//  clk        in   1       single clock, rising edge
//  reset      in   1       synchronous, active-high
//  start      in   1       request; accepted only in IDLE
//  n_pulses   in   CNT_W   number of sequences; latched on accepted start
//  b_hold     in   HOLD_W  B high cycles per sequence; latched on start; 0 treated as 1
//  q_in       in   1       detector Q, combinational from detector state
//  A          out  1       sequence first symbol
//  B          out  1       sequence second symbol
//  busy       out  1       1 whenever state != IDLE
//  done       out  1       one-cycle pulse at end of run
//  err        out  1       sticky Q-mismatch flag; cleared on accepted start
//  pulses_ok  out  CNT_W   sequences with no Q mismatch in their window; cleared on start
// BEHAVIOUR
//  Reset: state=IDLE; A=B=busy=done=err=0; pulses_ok=0; internal counters=0.
//  Reset mid-run aborts immediately; next cycle all outputs are at reset values.
//  Outputs A, B, busy, done are Moore, decoded from registered state.
//  States:
//   IDLE: start=1 -> latch n_pulses,b_hold; clear err,pulses_ok.
//         n_pulses==0 -> DONE; else -> ARM.
//   ARM:  A=1, B=0, 1 cycle -> HOLD.
//   HOLD: A=0, B=1 for max(b_hold,1) cycles -> GAP.
//   GAP:  A=B=0 for GAP cycles -> ARM if sequences remain, else DONE.
//   DONE: done=1, busy=1, 1 cycle -> IDLE.
//  Latency: start sampled in cycle s -> A=1 in cycle s+1.
//  Period per sequence: 1+H+GAP cycles.
//  Detector timing: Q=1 lags B by exactly one cycle.
//  Q check:
//   - exp_q = B delayed by one register.
//   - While in ARM/HOLD/GAP, q_in!=exp_q sets err and marks the current sequence bad.
//   - Last GAP cycle: pulses_ok += 1 if the sequence was not marked bad; bad mark clears.
//  pulses_ok is CNT_W wide; it cannot exceed n_pulses, so it never wraps.
//  start while busy is ignored, including in the DONE cycle. Latched values hold for the run.
//  Inputs changing mid-run have no effect.
//  n_pulses = 2^CNT_W-1 and b_hold = 2^HOLD_W-1 are legal and run to completion.
// STRUCTURE
//  Package ab_seq_pkg:
//   - state enum: IDLE, ARM, HOLD, GAP, DONE.
//   - localparam GAP_MIN=2.
//  One sub-module ab_cycle_cnt: loadable down-counter (WIDTH param, load, en, zero flag).
//  Instantiated twice:
//   - hold/gap cycle count, width max(HOLD_W, $clog2(GAP+1)).
//   - remaining sequences, CNT_W.
// TESTING
//  Every scenario uses a bench model of the detector driven by A/B, supplying q_in.
//  1 Basic run: start@0, n=3, b_hold=2.
//    -> A=1 @1,6,11; B=1 @2-3,7-8,12-13; done @16.
//    -> pulses_ok=3, err=0.
//  2 Zero count: start with n=0 -> done @1, busy=1 @1 only, A/B never high, pulses_ok=0.
//  3 b_hold=0, n=1: treated as 1 -> A@1, B@2, GAP @3-4, done@5, pulses_ok=1.
//  4 Fault injection: force q_in=0 during pulse 2 of n=3, b_hold=2.
//    -> err=1 from cycle 8, stays high; final pulses_ok=2.
//    -> next start clears err and pulses_ok.
//  5 Run interference: start=1 every cycle during a run (n=2, b_hold=3) -> ignored, one done only.
//    Reset asserted at cycle 4 -> A=B=busy=err=0 next cycle.
//    Clean restart works afterwards.
//  6 Boundary: n=255, b_hold=15 (defaults) -> done at cycle 255*18+1=4591; pulses_ok=255.

Source files
------------

// File: rtl/ab_seq_pkg.sv
// ab_seq_pkg
//   Shared types and constants for the A-then-B sequence generator.
//   - state_t : sequencer states
//   - GAP_MIN : smallest legal idle gap after each B hold
//   - max_int : elaboration helper for sizing the shared hold/gap counter
package ab_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_HOLD = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam int GAP_MIN = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ab_cycle_cnt.sv
// ab_cycle_cnt
//   Loadable down-counter that stops at zero.
//   Ports:
//     clk       in   clock, rising edge
//     reset     in   synchronous, active-high; clears the count
//     load      in   load load_val (has priority over en)
//     load_val  in   WIDTH  value to load
//     en        in   decrement by one when not already zero
//     zero      out  terminal count (count == 0)
module ab_cycle_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !zero) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ab_seq_gen.sv
// ab_seq_gen
//   Stimulus source and checker for an A-then-B sequence detector.
//   Emits n_pulses sequences of "A for one cycle, B for max(b_hold,1) cycles,
//   then GAP idle cycles", compares the detector's Q against B delayed by one
//   cycle, and counts sequences that saw no mismatch.
//   Ports:
//     clk        in   clock, rising edge
//     reset      in   synchronous, active-high
//     start      in   run request, accepted only in IDLE
//     n_pulses   in   CNT_W   sequences per run (latched on accepted start)
//     b_hold     in   HOLD_W  B high cycles per sequence (0 behaves as 1)
//     q_in       in   detector Q
//     A, B       out  sequence symbols (Moore)
//     busy       out  high whenever not IDLE (Moore)
//     done       out  one-cycle end-of-run pulse (Moore)
//     err        out  sticky Q mismatch flag, cleared on accepted start
//     pulses_ok  out  CNT_W   clean sequences this run, cleared on start
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for start
//   ARM    | A=1 for one cycle; loads the B hold length
//   HOLD   | B=1 until the hold counter reaches zero
//   GAP    | A=B=0 for GAP cycles; last cycle scores the sequence
//   DONE   | done=1 for one cycle, then back to IDLE
module ab_seq_gen
  import ab_seq_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int HOLD_W = 4,
  parameter int GAP    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  n_pulses,
  input  logic [HOLD_W-1:0] b_hold,
  input  logic              q_in,
  output logic              A,
  output logic              B,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  pulses_ok
);

  // one counter times both the B hold and the idle gap, so it must fit either
  localparam int HG_W = max_int(HOLD_W, $clog2(GAP + 1));

  if (GAP < GAP_MIN) begin : g_gap_chk
    $error("ab_seq_gen: GAP=%0d is below the minimum of %0d", GAP, GAP_MIN);
  end

  state_t            state, state_nxt;
  logic [HOLD_W-1:0] hold_lat;
  logic [HOLD_W-1:0] hold_m1;
  logic [CNT_W-1:0]  n_m1;

  logic              start_acc;
  logic              hg_load, hg_en, hg_zero;
  logic [HG_W-1:0]   hg_val;
  logic              seq_load, seq_en, seq_zero;

  logic              exp_q;
  logic              checking;
  logic              mismatch;
  logic              last_gap;
  logic              err_r;
  logic              seq_bad;

  assign hold_m1 = hold_lat - HOLD_W'(1);
  assign n_m1    = n_pulses - CNT_W'(1);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    hg_load   = 1'b0;
    hg_val    = '0;
    hg_en     = 1'b0;
    seq_load  = 1'b0;
    seq_en    = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          // remaining-sequence counter holds "sequences after this one"
          seq_load  = 1'b1;
          state_nxt = (n_pulses == '0) ? S_DONE : S_ARM;
        end
      end
      S_ARM: begin
        hg_load   = 1'b1;
        hg_val    = HG_W'(hold_m1);
        state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (hg_zero) begin
          hg_load   = 1'b1;
          hg_val    = HG_W'(GAP - 1);
          state_nxt = S_GAP;
        end else begin
          hg_en = 1'b1;
        end
      end
      S_GAP: begin
        if (hg_zero) begin
          if (seq_zero) begin
            state_nxt = S_DONE;
          end else begin
            seq_en    = 1'b1;
            state_nxt = S_ARM;
          end
        end else begin
          hg_en = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign A    = (state == S_ARM);
  assign B    = (state == S_HOLD);
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // ------------------------------------------------------------ counters
  ab_cycle_cnt #(
    .WIDTH (HG_W)
  ) u_hg_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (hg_load),
    .load_val (hg_val),
    .en       (hg_en),
    .zero     (hg_zero)
  );

  ab_cycle_cnt #(
    .WIDTH (CNT_W)
  ) u_seq_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (seq_load),
    .load_val (n_m1),
    .en       (seq_en),
    .zero     (seq_zero)
  );

  // b_hold of zero runs as a single B cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_lat <= '0;
    end else if (start_acc) begin
      hold_lat <= (b_hold == '0) ? HOLD_W'(1) : b_hold;
    end
  end

  // ------------------------------------------------------------- Q check
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q <= 1'b0;
    end else begin
      exp_q <= B;
    end
  end

  assign checking = (state == S_ARM) || (state == S_HOLD) || (state == S_GAP);
  assign mismatch = checking && (q_in != exp_q);
  assign last_gap = (state == S_GAP) && hg_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_r     <= 1'b0;
      seq_bad   <= 1'b0;
      pulses_ok <= '0;
    end else if (start_acc) begin
      err_r     <= 1'b0;
      seq_bad   <= 1'b0;
      pulses_ok <= '0;
    end else begin
      if (mismatch) begin
        err_r <= 1'b1;
      end
      if (last_gap) begin
        seq_bad <= 1'b0;
        // a mismatch on the scoring cycle itself still spoils the sequence
        if (!(seq_bad || mismatch)) begin
          pulses_ok <= pulses_ok + CNT_W'(1);
        end
      end else if (mismatch) begin
        seq_bad <= 1'b1;
      end
    end
  end

  // the flag rises in the same cycle as the offending Q sample
  assign err = err_r || mismatch;

endmodule

// File: tb/tb_ab_seq_gen.sv
// tb_ab_seq_gen
//   Self-checking bench for ab_seq_gen. A one-register detector model
//   supplies q_in (optionally forced low), and a scoreboard of per-cycle
//   expected outputs is built when each run is started.
module tb_ab_seq_gen;

  localparam int CNT_W  = 8;
  localparam int HOLD_W = 4;
  localparam int GAP    = 2;

  logic              clk;
  logic              reset;
  logic              start;
  logic [CNT_W-1:0]  n_pulses;
  logic [HOLD_W-1:0] b_hold;
  logic              q_in;
  logic              A, B, busy, done, err;
  logic [CNT_W-1:0]  pulses_ok;

  logic q_reg;
  logic q_force;

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic             a;
    logic             b;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] pok;
    logic             inj;
  } sb_t;

  sb_t sb[$];

  ab_seq_gen #(
    .CNT_W  (CNT_W),
    .HOLD_W (HOLD_W),
    .GAP    (GAP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .n_pulses  (n_pulses),
    .b_hold    (b_hold),
    .q_in      (q_in),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .pulses_ok (pulses_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // detector: Q follows B one cycle later
  always @(posedge clk) q_reg <= reset ? 1'b0 : B;
  assign q_in = q_force ? 1'b0 : q_reg;

  initial begin
    #1000000;
    $display("FAIL watchdog: time=%0t limit reached", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {19'd0, A, B, busy, done, err, pulses_ok};
  endfunction

  // expected outputs for cycles 1.. after the start cycle
  task automatic build(input int n, input int h, input int inj_seq);
    int   hh;
    int   pk;
    logic pb;
    logic e;
    logic bad;
    logic a_x, b_x, inj, mism;
    hh = (h == 0) ? 1 : h;
    pk = 0;
    pb = 1'b0;
    e  = 1'b0;
    sb.delete();
    for (int s = 1; s <= n; s++) begin
      bad = 1'b0;
      for (int c = 0; c < 1 + hh + GAP; c++) begin
        a_x  = (c == 0);
        b_x  = (c >= 1) && (c <= hh);
        inj  = (s == inj_seq);
        mism = inj && pb;
        if (mism) begin
          e   = 1'b1;
          bad = 1'b1;
        end
        sb.push_back('{a_x, b_x, 1'b1, 1'b0, e, CNT_W'(pk), inj});
        pb = b_x;
      end
      if (!bad) pk++;
    end
    sb.push_back('{1'b0, 1'b0, 1'b1, 1'b1, e, CNT_W'(pk), 1'b0});
    sb.push_back('{1'b0, 1'b0, 1'b0, 1'b0, e, CNT_W'(pk), 1'b0});
  endtask

  task automatic run(input string nm, input int n, input int h, input int inj_seq,
                     input bit hammer, input int rst_at);
    sb_t e;
    int  k;
    int  dones;
    int  done_cyc;
    int  hh;
    hh = (h == 0) ? 1 : h;
    build(n, h, inj_seq);
    @(posedge clk); #1;
    start    = 1'b1;
    n_pulses = CNT_W'(n);
    b_hold   = HOLD_W'(h);
    k        = 0;
    dones    = 0;
    done_cyc = -1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      k++;
      @(posedge clk); #1;
      if (rst_at != 0 && k == rst_at) begin
        reset   = 1'b1;
        start   = 1'b0;
        q_force = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk($sformatf("%s_after_reset", nm), obs(), 32'd0);
        sb.delete();
        break;
      end
      // start is held through DONE when hammering; it must be ignored
      start    = hammer && e.busy;
      n_pulses = CNT_W'($urandom);
      b_hold   = HOLD_W'($urandom);
      q_force  = e.inj;
      @(negedge clk);
      chk($sformatf("%s_c%0d", nm, k), obs(),
          {19'd0, e.a, e.b, e.busy, e.done, e.err, e.pok});
      if (done) begin
        dones++;
        done_cyc = k;
      end
    end
    start   = 1'b0;
    q_force = 1'b0;
    if (rst_at == 0) begin
      chk($sformatf("%s_done_cnt", nm), 32'(dones), 32'd1);
      chk($sformatf("%s_done_cyc", nm), 32'(done_cyc), 32'(1 + n * (1 + hh + GAP)));
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    n_pulses = '0;
    b_hold   = '0;
    q_force  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_state", obs(), 32'd0);

    run("basic",    3, 2, 0, 1'b0, 0);
    run("zero_n",   0, 5, 0, 1'b0, 0);
    run("hold0",    1, 0, 0, 1'b0, 0);
    run("fault",    3, 2, 2, 1'b0, 0);
    run("clear",    1, 1, 0, 1'b0, 0);
    run("hammer",   2, 3, 0, 1'b1, 0);
    run("midreset", 2, 3, 1, 1'b1, 4);
    run("restart",  1, 2, 0, 1'b0, 0);
    run("max",    255, 15, 0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
